// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor.
// One full-adder stage processes a single bit pair per clock, LSB first.
// Operands are captured on start, sum/cout update only when the last bit
// has been added, and done pulses for the single cycle spent in DONE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  // Full-adder carry bit.
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (c & (x ^ y));
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] res_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             capture_s;
  logic             last_s;
  logic             bit_s;
  logic             carry_next_s;
  logic [WIDTH-1:0] res_next_s;

  // Next-state logic and the single full-adder stage.
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    last_s       = 1'b0;
    bit_s        = fa_sum(op_a_r[0], op_b_r[0], carry_r);
    carry_next_s = fa_carry(op_a_r[0], op_b_r[0], carry_r);
    res_next_s   = {bit_s, res_r[WIDTH-1:1]};
    case (state_r)
      IDLE: begin
        if (start) begin
          capture_s    = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          last_s       = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          capture_s    = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Operand capture, per-bit shifting and the result load on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_r  <= {WIDTH{1'b0}};
      op_b_r  <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      carry_r <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
    end else if (capture_s) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
      op_a_r  <= a;
      op_b_r  <= sub ? ~b : b;
      carry_r <= sub ? 1'b1 : cin;
      res_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      op_a_r  <= op_a_r >> 1;
      op_b_r  <= op_b_r >> 1;
      carry_r <= carry_next_s;
      res_r   <= res_next_s;
      cnt_r   <= cnt_r + CW'(1);
      // The final bit is still in flight, so load from the shifted value.
      if (last_s) begin
        sum_r  <= res_next_s;
        cout_r <= carry_next_s;
      end else begin
        sum_r  <= sum_r;
        cout_r <= cout_r;
      end
    end else begin
      op_a_r  <= op_a_r;
      op_b_r  <= op_b_r;
      carry_r <= carry_r;
      res_r   <= res_r;
      cnt_r   <= cnt_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH = 8).
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks;
  int errors;

  logic [W-1:0] held_sum;
  logic         held_cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sub  (sub),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: add is a+b+cin; subtract is a-b offset by 2^W so bit W means "no borrow".
  function automatic logic [W:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rc, input logic rs);
    int r;
    if (rs) r = int'(ra) + 256 - int'(rb);
    else    r = int'(ra) + int'(rb) + int'(rc);
    return r[W:0];
  endfunction

  // Called at a negedge: present operands with start, leave at the first RUN-cycle negedge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts);
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checks the W RUN cycles and the DONE cycle; leaves at the DONE-cycle negedge.
  task automatic run_and_check(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               input logic tc, input logic ts, input bit scramble);
    logic [W:0] exp;
    exp = ref_result(ta, tb_v, tc, ts);
    for (int i = 0; i < W; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s run%0d busy/done got %b/%b want 1/0", name, i, busy, done);
      end
      checks++;
      if (sum !== held_sum || cout !== held_cout) begin
        errors++;
        $display("FAIL %s run%0d held sum/cout got %h/%b want %h/%b", name, i, sum, cout, held_sum, held_cout);
      end
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        start = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done-cycle busy/done got %b/%b want 0/1", name, busy, done);
    end
    checks++;
    if (sum !== exp[W-1:0] || cout !== exp[W]) begin
      errors++;
      $display("FAIL %s result a=%h b=%h cin=%b sub=%b got %h/%b want %h/%b",
               name, ta, tb_v, tc, ts, sum, cout, exp[W-1:0], exp[W]);
    end
    held_sum  = exp[W-1:0];
    held_cout = exp[W];
  endtask

  // One cycle after DONE without start the block must be idle.
  task automatic check_idle(input string name);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle busy/done got %b/%b want 0/0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset got busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy, done, sum, cout);
    end
    rst = 1'b0;
    held_sum = 8'h00; held_cout = 1'b0;
    check_idle("reset_release");
  endtask

  task automatic test_directed();
    start_op(8'h00, 8'h00, 1'b0, 1'b0); run_and_check("zero",  8'h00, 8'h00, 1'b0, 1'b0, 1'b0); check_idle("zero");
    start_op(8'hFF, 8'h01, 1'b0, 1'b0); run_and_check("wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 1'b0); check_idle("wrap");
    start_op(8'hA5, 8'h5A, 1'b1, 1'b0); run_and_check("cin",   8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0); check_idle("cin");
    start_op(8'h10, 8'h01, 1'b1, 1'b1); run_and_check("sub",   8'h10, 8'h01, 1'b1, 1'b1, 1'b0); check_idle("sub");
    start_op(8'h01, 8'h02, 1'b0, 1'b1); run_and_check("borrow",8'h01, 8'h02, 1'b0, 1'b1, 1'b0); check_idle("borrow");
  endtask

  // Random operands; inputs and start are scrambled throughout RUN.
  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic rc, rs;
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      start_op(ra, rb, rc, rs);
      run_and_check("random", ra, rb, rc, rs, 1'b1);
      check_idle("random");
    end
  endtask

  // start during the DONE cycle launches the next operation with no gap.
  task automatic test_back_to_back();
    logic [W-1:0] ra, rb;
    logic rc, rs;
    for (int n = 0; n < 4; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      start_op(ra, rb, rc, rs);
      run_and_check("b2b", ra, rb, rc, rs, 1'b1);
    end
    check_idle("b2b_end");
  endtask

  // Reset in the 4th RUN cycle aborts the operation with no done pulse.
  task automatic test_reset_mid_run();
    start_op(8'h37, 8'h4C, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy, done, sum, cout);
    end
    held_sum = 8'h00; held_cout = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h00) begin
        errors++;
        $display("FAIL midrun_quiet cyc%0d got busy=%b done=%b sum=%h want 0 0 00", i, busy, done, sum);
      end
    end
    start_op(8'h81, 8'h7F, 1'b0, 1'b0);
    run_and_check("after_reset", 8'h81, 8'h7F, 1'b0, 1'b0, 1'b0);
    check_idle("after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    held_sum = 8'h00; held_cout = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
